// File: rtl/load_sequencer.sv
// Serial-to-parallel frame collector that hands a 16-value frame to a loader via permit/ack.
// Optional even-parity check on a 17th bit is enabled by defining PARITY_CHECK_EN.
module load_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_bit_in,
  input  logic        i_bit_valid,
  input  logic        i_ack,
  output logic [1:16] o_values,
  output logic        o_permit,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_err
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {StIdle, StCollect, StHold, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;
`endif

  localparam logic [7:0] HoldLast = 8'(ACK_TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic [4:0]  r_count, w_count_d;
  logic [7:0]  r_hold_cnt, w_hold_cnt_d;
  logic [1:16] r_values, w_values_d;
  logic        r_permit, w_permit_d;
  logic        r_busy, w_busy_d;
  logic        r_timeout, w_timeout_d;
  logic        r_err, w_err_d;

`ifdef PARITY_CHECK_EN
  logic w_parity;
  assign w_parity = ^r_values;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_hold_cnt_d = r_hold_cnt;
    w_values_d   = r_values;
    w_permit_d   = r_permit;
    w_timeout_d  = 1'b0;
    w_err_d      = r_err;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d  = StCollect;
          w_count_d  = 5'd0;
          w_values_d = '0;
        end
      end
      StCollect: begin
        if (i_bit_valid) begin
          for (int i = 1; i <= 16; i++) begin
            if (r_count == 5'(i - 1)) w_values_d[i] = i_bit_in;
          end
          w_count_d = r_count + 5'd1;
          if (r_count == 5'd15) begin
`ifdef PARITY_CHECK_EN
            w_state_d = StParity;
`else
            w_state_d    = StHold;
            w_permit_d   = 1'b1;
            w_hold_cnt_d = 8'd0;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      StParity: begin
        if (i_bit_valid) begin
          if (i_bit_in == w_parity) begin
            w_state_d    = StHold;
            w_permit_d   = 1'b1;
            w_hold_cnt_d = 8'd0;
          end else begin
            w_state_d = StIdle;
            w_err_d   = 1'b1;
          end
        end
      end
`endif
      StHold: begin
        // ack has priority over an expiring timeout in the same cycle
        if (i_ack) begin
          w_state_d  = StIdle;
          w_permit_d = 1'b0;
        end else if (r_hold_cnt == HoldLast) begin
          w_state_d   = StIdle;
          w_permit_d  = 1'b0;
          w_timeout_d = 1'b1;
        end else begin
          w_hold_cnt_d = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_d  = StIdle;
        w_permit_d = 1'b0;
      end
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_count    <= 5'd0;
      r_hold_cnt <= 8'd0;
      r_values   <= '0;
      r_permit   <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_values   <= w_values_d;
      r_permit   <= w_permit_d;
      r_busy     <= w_busy_d;
      r_timeout  <= w_timeout_d;
      r_err      <= w_err_d;
    end
  end

  assign o_values  = r_values;
  assign o_permit  = r_permit;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;
`ifdef PARITY_CHECK_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_sequencer.sv
// Scenario bench for load_sequencer: expected frames are queued when driven and
// compared when permit rises.
module tb_load_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic        ack;
  logic [1:16] values;
  logic        permit;
  logic        busy;
  logic        timeout;
  logic        err;

  int checks;
  int failures;
  logic [1:16] exp_q[$];

  load_sequencer #(.ACK_TIMEOUT(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_bit_in   (bit_in),
    .i_bit_valid(bit_valid),
    .i_ack      (ack),
    .o_values   (values),
    .o_permit   (permit),
    .o_busy     (busy),
    .o_timeout  (timeout),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_bits(input logic [1:16] pat, input int first, input int last,
                            input int max_gap);
    for (int i = first; i <= last; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) tick();
      bit_valid = 1'b1;
      bit_in    = pat[i];
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  // With parity checking the frame is closed by a correct even-parity bit.
  task automatic drive_tail(input logic [1:16] pat);
`ifdef PARITY_CHECK_EN
    bit_valid = 1'b1;
    bit_in    = ^pat;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
`else
    if (pat === 'x) tick();
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 0; bit_in = 0; bit_valid = 0; ack = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL reset_permit got=%b exp=0", permit); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (values !== 16'h0000) begin failures++; $display("FAIL reset_values got=%h exp=0000", values); end
    start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_held got=%b exp=0", busy); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_release_start got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_async_busy got=%b exp=0", busy); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [1:16] pat;
    logic [1:16] exp;
    pat = 16'b1011_0000_1111_0101;
    exp_q.push_back(pat);
    drive_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    drive_bits(pat, 1, 15, 0);
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL basic_early_permit got=%b exp=0", permit); end
    drive_bits(pat, 16, 16, 0);
    drive_tail(pat);
    checks++; if (permit !== 1'b1) begin failures++; $display("FAIL basic_permit got=%b exp=1", permit); end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL basic_sb got=empty exp=frame");
    end else begin
      exp = exp_q.pop_front();
      if (values !== exp) begin failures++; $display("FAIL basic_values got=%h exp=%h", values, exp); end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL basic_ack_permit got=%b exp=0", permit); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_ack_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL basic_ack_timeout got=%b exp=0", timeout); end
  endtask

  // Gapped frames, each started immediately after the previous ack.
  task automatic test_back_to_back();
    logic [1:16] pat;
    logic [1:16] exp;
    for (int f = 0; f < 3; f++) begin
      pat = 16'($urandom);
      exp_q.push_back(pat);
      drive_start();
      drive_bits(pat, 1, 15, 3);
      checks++; if (permit !== 1'b0) begin failures++; $display("FAIL gap_early_permit f=%0d got=%b exp=0", f, permit); end
      drive_bits(pat, 16, 16, 3);
      drive_tail(pat);
      checks++; if (permit !== 1'b1) begin failures++; $display("FAIL gap_permit f=%0d got=%b exp=1", f, permit); end
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL gap_sb f=%0d got=empty exp=frame", f);
      end else begin
        exp = exp_q.pop_front();
        if (values !== exp) begin failures++; $display("FAIL gap_values f=%0d got=%h exp=%h", f, values, exp); end
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_busy f=%0d got=%b exp=0", f, busy); end
    end
  endtask

  task automatic test_timeout();
    logic [1:16] pat;
    logic [1:16] exp;
    int cyc;
    pat = 16'h3C96;
    exp_q.push_back(pat);
    drive_start();
    drive_bits(pat, 1, 16, 1);
    drive_tail(pat);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    cyc = 0;
    while (permit === 1'b1 && cyc < 20) begin
      cyc++;
      checks++; if (values !== exp) begin failures++; $display("FAIL to_values_stable got=%h exp=%h", values, exp); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early_pulse got=%b exp=0", timeout); end
      tick();
    end
    checks++; if (cyc != 4) begin failures++; $display("FAIL to_permit_cycles got=%0d exp=4", cyc); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", busy); end
    checks++; if (values !== exp) begin failures++; $display("FAIL to_values_kept got=%h exp=%h", values, exp); end
    tick();
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout); end
    // ack and start on the expiry cycle: ack wins, start ignored
    pat = 16'h5A0F;
    drive_start();
    drive_bits(pat, 1, 16, 0);
    drive_tail(pat);
    repeat (3) tick();
    ack = 1'b1; start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b0;
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL race_permit got=%b exp=0", permit); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL race_timeout got=%b exp=0", timeout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL race_start got=%b exp=0", busy); end
  endtask

  task automatic test_mid_reset();
    logic [1:16] pat;
    logic [1:16] exp;
    pat = 16'hA5C3;
    drive_start();
    drive_bits(pat, 1, 8, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (values !== 16'h0000) begin failures++; $display("FAIL mid_values got=%h exp=0000", values); end
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL mid_permit got=%b exp=0", permit); end
    #2 rst_n = 1'b1;
    tick();
    pat = 16'h1E69;
    exp_q.push_back(pat);
    drive_start();
    drive_bits(pat, 1, 16, 2);
    drive_tail(pat);
    checks++; if (permit !== 1'b1) begin failures++; $display("FAIL clean_permit got=%b exp=1", permit); end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL clean_sb got=empty exp=frame");
    end else begin
      exp = exp_q.pop_front();
      if (values !== exp) begin failures++; $display("FAIL clean_values got=%h exp=%h", values, exp); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL hold_reset_permit got=%b exp=0", permit); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ignore();
    logic [1:16] pat;
    logic [1:16] part;
    logic [1:16] exp;
    pat = 16'hC3A5;
    part = '0;
    for (int i = 1; i <= 5; i++) part[i] = pat[i];
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_ack got=%b exp=0", busy); end
    exp_q.push_back(pat);
    drive_start();
    drive_bits(pat, 1, 5, 0);
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
    checks++; if (values !== part) begin failures++; $display("FAIL ign_values got=%h exp=%h", values, part); end
    drive_bits(pat, 6, 15, 0);
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL ign_early_permit got=%b exp=0", permit); end
    drive_bits(pat, 16, 16, 0);
    drive_tail(pat);
    checks++; if (permit !== 1'b1) begin failures++; $display("FAIL ign_permit got=%b exp=1", permit); end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL ign_sb got=empty exp=frame");
    end else begin
      exp = exp_q.pop_front();
      if (values !== exp) begin failures++; $display("FAIL ign_frame got=%h exp=%h", values, exp); end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    logic [1:16] pat;
    pat = 16'hFFFF;
    drive_start();
    drive_bits(pat, 1, 16, 0);
    checks++; if (permit !== 1'b0) begin failures++; $display("FAIL par_wait_permit got=%b exp=0", permit); end
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    bit_valid = 1'b0; bit_in = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL par_busy got=%b exp=0", busy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (permit !== 1'b0) begin failures++; $display("FAIL par_permit got=%b exp=0", permit); end
      tick();
    end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", err); end
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    drive_start();
    drive_bits(pat, 1, 16, 0);
    bit_valid = 1'b1; bit_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    checks++; if (permit !== 1'b1) begin failures++; $display("FAIL par_ok_permit got=%b exp=1", permit); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL par_ok_err got=%b exp=0", err); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    test_ignore();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
